prbs_pd_scheduler: RTL and testbench
====================================

Name: prbs_pd_scheduler

Overview:
- Shares one pattern serializer/detector datapath (32-bit word in, 8-bit bytes out MSB-first, repeat count n, pattern_detected flag) among NUM_REQ requesters.
- Round-robin arbitrates requests, latches the winner's word and repeat count, and drives the datapath for exactly 4*n byte cycles.
- Samples the detector's verdict and returns a one-cycle done pulse with a pass/fail result to the granted requester.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DETECT_LAT, 1, cycles after the last byte cycle before dp_pattern_detected is sampled (1..7).
- CNT_W, 10, width of the byte-cycle counter; must hold 4*255.

Ports:
- CLK  in  1  clock, rising edge.
- RSTn  in  1  asynchronous active-low reset.
- req  in  NUM_REQ  per-requester request level.
- req_word  in  NUM_REQ*32  packed words; requester i uses bits [32*i+31:32*i].
- req_n  in  NUM_REQ*8  packed repeat counts; requester i uses bits [8*i+7:8*i].
- gnt  out  NUM_REQ  one-hot, one-cycle pulse when a request is accepted.
- done  out  NUM_REQ  one-hot, one-cycle pulse when the result is ready.
- pass  out  1  verdict; valid only while any done bit is high, 0 otherwise.
- busy  out  1  high in every state except IDLE.
- dp_data_valid  out  1  datapath data_valid.
- dp_in  out  32  datapath word.
- dp_n  out  8  datapath repeat count.
- dp_pattern_detected  in  1  datapath detector flag.

Behaviour:
- Reset: all outputs 0, FSM in IDLE, round-robin pointer 0, counters 0. Reset applies immediately, including mid-transaction. No done pulse is issued for an aborted transaction.
- States: IDLE, LOAD, RUN, SETTLE, REPORT.
- IDLE:
  - If req != 0, select the first set bit at or after the pointer (wrapping), pulse gnt for that bit, latch its word and n, and go to LOAD.
  - The pointer becomes winner+1 mod NUM_REQ.
- Zero repeat count: if latched n == 0, go straight from IDLE to REPORT with pass=0. The datapath is never driven.
- LOAD (1 cycle): dp_data_valid=1; dp_in and dp_n present the latched values; byte counter cleared.
- RUN: dp_data_valid=1; the counter increments each cycle. Exit to SETTLE after 4*n cycles, counted as 4*n-1 in CNT_W-bit arithmetic; no 8-bit overflow.
- SETTLE: dp_data_valid=0. After DETECT_LAT cycles, register dp_pattern_detected into the result and go to REPORT.
- REPORT (1 cycle): done[winner]=1 and pass=result, then return to IDLE.
  - Minimum spacing between done and the next gnt is 1 cycle.
- dp_in and dp_n hold the latched values from LOAD through REPORT and keep them in IDLE. They are not required to be 0 after the first grant.
- req may fall after gnt; the transaction still completes. req changes during a transaction are ignored until IDLE.
- A requester holding req after its own done is re-arbitrated behind the other pending requesters.
- Total latency from gnt to done = 1 + 4*n + DETECT_LAT + 1 cycles.

Optional Feature:
- Macro: PRBS_PD_SCHED_STATS_EN.
- Defined:
  - Adds output pass_cnt[NUM_REQ*16] and fail_cnt[NUM_REQ*16].
  - Each is a 16-bit saturating counter per requester, incremented in REPORT and cleared by reset.
  - Saturates at 16'hFFFF with no wrap.
- Undefined: those ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Package prbs_pd_sched_pkg: state enum (IDLE, LOAD, RUN, SETTLE, REPORT), BYTES_PER_WORD=4, WORD_W=32, BYTE_W=8, N_W=8, STAT_W=16.
- One sub-module: prbs_rr_arbiter.
  - Inputs: req, pointer. Output: one-hot winner plus index.
  - Purely combinational.
  - The pointer register stays in the scheduler.

Test Plan:
- Reset: hold RSTn=0 for 3 cycles with req=4'b1111 -> gnt, done, pass, busy and dp_data_valid are all 0.
- Single matching request: req[0], word 32'hABCDEFCD (equal to the datapath pattern), n=3 -> gnt[0] pulse, dp_data_valid high for 13 cycles, done[0] 15 cycles after gnt, pass=1.
- Mismatch: req[1], word 32'hAABBCCDD, n=1 -> done[1] with pass=0 after 1+4+1+1 cycles.
- Round robin: req=4'b1011 held high -> grant order 0, 1, 3, 0; no overlapping busy windows.
- Edge cases:
  - n=0 on req[2] -> done[2] with pass=0 within 2 cycles of gnt; dp_data_valid never rises.
  - RSTn pulsed low mid-RUN -> outputs clear asynchronously and no done pulse is issued.
- With PRBS_PD_SCHED_STATS_EN: 3 passes and 2 fails on requester 0 -> pass_cnt[0]=3, fail_cnt[0]=2; all other requesters' counts stay 0.

Source files
------------

// File: rtl/prbs_pd_sched_pkg.sv
// Shared types and widths for the PRBS pattern-detector scheduler.
package prbs_pd_sched_pkg;

    localparam int BYTES_PER_WORD = 4;
    localparam int BYTE_W         = 8;
    localparam int WORD_W         = BYTES_PER_WORD * BYTE_W;
    localparam int N_W            = 8;
    localparam int STAT_W         = 16;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RUN,
        SETTLE,
        REPORT
    } state_e;

    typedef struct packed {
        logic [WORD_W-1:0] word;
        logic [N_W-1:0]    n;
    } job_t;

endpackage

// File: rtl/prbs_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping.
module prbs_rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] win_oh,
    output logic [IDX_W-1:0]   win_idx,
    output logic               win_vld
);

    always_comb begin
        int j;
        j       = 0;
        win_oh  = '0;
        win_idx = '0;
        win_vld = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            j = (int'(ptr) + i) % NUM_REQ;
            if (!win_vld && req[j]) begin
                win_vld    = 1'b1;
                win_oh[j]  = 1'b1;
                win_idx    = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/prbs_pd_scheduler.sv
// Round-robin scheduler sharing one PRBS serializer/detector among NUM_REQ requesters.
// Optional per-requester pass/fail counters when PRBS_PD_SCHED_STATS_EN is defined.
module prbs_pd_scheduler
    import prbs_pd_sched_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DETECT_LAT = 1,
    parameter int CNT_W      = 10
) (
    input  logic                      CLK,
    input  logic                      RSTn,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*WORD_W-1:0] req_word,
    input  logic [NUM_REQ*N_W-1:0]    req_n,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [NUM_REQ-1:0]        done,
    output logic                      pass,
    output logic                      busy,
    output logic                      dp_data_valid,
    output logic [WORD_W-1:0]         dp_in,
    output logic [N_W-1:0]            dp_n,
    input  logic                      dp_pattern_detected
`ifdef PRBS_PD_SCHED_STATS_EN
    ,
    output logic [NUM_REQ*STAT_W-1:0] pass_cnt,
    output logic [NUM_REQ*STAT_W-1:0] fail_cnt
`endif
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    state_e             state_q, state_d;
    job_t               job_q, job_d, arb_job;
    logic [IDX_W-1:0]   ptr_q, ptr_d, win_q, win_d, arb_idx;
    logic [NUM_REQ-1:0] arb_oh;
    logic               arb_vld;
    logic [CNT_W-1:0]   cnt_q, cnt_d, last_byte;
    logic               result_q, result_d;
    logic               arm_q;

    prbs_rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_arb (
        .req     (req),
        .ptr     (ptr_q),
        .win_oh  (arb_oh),
        .win_idx (arb_idx),
        .win_vld (arb_vld)
    );

    assign arb_job.word = req_word[int'(arb_idx)*WORD_W +: WORD_W];
    assign arb_job.n    = req_n[int'(arb_idx)*N_W +: N_W];

    // Byte cycles run 0 .. 4n-1; widened so n up to 255 never wraps.
    assign last_byte = CNT_W'(job_q.n) * CNT_W'(BYTES_PER_WORD) - CNT_W'(1);

    always_comb begin
        state_d  = state_q;
        job_d    = job_q;
        ptr_d    = ptr_q;
        win_d    = win_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        gnt      = '0;
        unique case (state_q)
            IDLE: begin
                // arm_q keeps gnt low while reset is held, when req may already be set.
                if (arm_q && arb_vld) begin
                    gnt      = arb_oh;
                    job_d    = arb_job;
                    win_d    = arb_idx;
                    ptr_d    = (int'(arb_idx) == NUM_REQ - 1) ? '0 : arb_idx + IDX_W'(1);
                    cnt_d    = '0;
                    result_d = 1'b0;
                    state_d  = (arb_job.n == '0) ? REPORT : LOAD;
                end
            end
            LOAD: begin
                cnt_d   = '0;
                state_d = RUN;
            end
            RUN: begin
                if (cnt_q == last_byte) begin
                    cnt_d   = '0;
                    state_d = SETTLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            SETTLE: begin
                if (cnt_q == CNT_W'(DETECT_LAT - 1)) begin
                    result_d = dp_pattern_detected;
                    state_d  = REPORT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            REPORT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q  <= IDLE;
            job_q    <= '0;
            ptr_q    <= '0;
            win_q    <= '0;
            cnt_q    <= '0;
            result_q <= 1'b0;
            arm_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            job_q    <= job_d;
            ptr_q    <= ptr_d;
            win_q    <= win_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            arm_q    <= 1'b1;
        end
    end

    assign busy          = (state_q != IDLE);
    assign dp_data_valid = (state_q == LOAD) || (state_q == RUN);
    assign dp_in         = job_q.word;
    assign dp_n          = job_q.n;
    assign done          = (state_q == REPORT) ? (NUM_REQ'(1) << win_q) : '0;
    assign pass          = (state_q == REPORT) && result_q;

`ifdef PRBS_PD_SCHED_STATS_EN
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_stat
        logic [STAT_W-1:0] pc_q, pc_d, fc_q, fc_d;

        always_comb begin
            pc_d = pc_q;
            fc_d = fc_q;
            if (state_q == REPORT && int'(win_q) == i) begin
                if (result_q && pc_q != '1)  pc_d = pc_q + STAT_W'(1);
                if (!result_q && fc_q != '1) fc_d = fc_q + STAT_W'(1);
            end
        end

        always_ff @(posedge CLK or negedge RSTn) begin
            if (!RSTn) begin
                pc_q <= '0;
                fc_q <= '0;
            end else begin
                pc_q <= pc_d;
                fc_q <= fc_d;
            end
        end

        assign pass_cnt[i*STAT_W +: STAT_W] = pc_q;
        assign fail_cnt[i*STAT_W +: STAT_W] = fc_q;
    end
`endif

endmodule

// File: tb/tb_prbs_pd_scheduler.sv
// Scoreboard bench: stimulus predicts each grant/verdict, a negedge monitor checks.
`timescale 1ns/1ps
module tb_prbs_pd_scheduler;
    import prbs_pd_sched_pkg::*;

    localparam int NR = 4;
    localparam int DL = 1;
    localparam int CW = 10;
    localparam logic [31:0] PAT = 32'hABCDEFCD;

    logic            CLK = 1'b0;
    logic            RSTn = 1'b0;
    logic [NR-1:0]   req;
    logic [NR*32-1:0] req_word;
    logic [NR*8-1:0] req_n;
    logic [NR-1:0]   gnt, done;
    logic            pass, busy, dp_data_valid, dp_pattern_detected;
    logic [31:0]     dp_in;
    logic [7:0]      dp_n;
`ifdef PRBS_PD_SCHED_STATS_EN
    logic [NR*16-1:0] pass_cnt, fail_cnt;
`endif

    always #5 CLK = ~CLK;

    prbs_pd_scheduler #(.NUM_REQ(NR), .DETECT_LAT(DL), .CNT_W(CW)) dut (
        .CLK(CLK), .RSTn(RSTn), .req(req), .req_word(req_word), .req_n(req_n),
        .gnt(gnt), .done(done), .pass(pass), .busy(busy),
        .dp_data_valid(dp_data_valid), .dp_in(dp_in), .dp_n(dp_n),
        .dp_pattern_detected(dp_pattern_detected)
`ifdef PRBS_PD_SCHED_STATS_EN
        , .pass_cnt(pass_cnt), .fail_cnt(fail_cnt)
`endif
    );

    // Datapath stand-in: flag is high only in the DL-th cycle after the last byte.
    logic cap;
    int   since;
    always @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            cap   <= 1'b0;
            since <= 0;
        end else if (dp_data_valid) begin
            cap   <= (dp_in == PAT);
            since <= 0;
        end else if (since < 100) begin
            since <= since + 1;
        end
    end
    assign dp_pattern_detected = cap && !dp_data_valid && (since == DL - 1);

    typedef struct { int idx; bit pass; int n; } exp_t;
    exp_t sbq[$];
    int   vectors = 0, miscompares = 0;
    int   mptr = 0;
    int   m_pass[NR], m_fail[NR];
    int   cyc = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int pick(input logic [NR-1:0] r);
        for (int k = 0; k < NR; k++)
            if (r[(mptr + k) % NR]) return (mptr + k) % NR;
        return -1;
    endfunction

    task automatic push_grant(input logic [NR-1:0] r);
        exp_t e;
        int w;
        w      = pick(r);
        e.idx  = w;
        e.n    = int'(req_n[w*8 +: 8]);
        e.pass = (req_word[w*32 +: 32] == PAT) && (e.n != 0);
        sbq.push_back(e);
        mptr = (w + 1) % NR;
        if (e.pass) m_pass[w]++; else m_fail[w]++;
    endtask

    task automatic set_slot(input int i, input logic [31:0] w, input logic [7:0] n);
        req_word[i*32 +: 32] = w;
        req_n[i*8 +: 8]      = n;
    endtask

    task automatic wait_idle();
        for (int t = 0; t < 3000; t++) begin
            @(posedge CLK); #1;
            if (!busy) return;
        end
        chk("idle_timeout", 1, 0);
    endtask

    task automatic do_txn(input logic [NR-1:0] mask);
        wait_idle();
        req = mask;
        push_grant(mask);
        @(posedge CLK); #1;
        req = '0;
    endtask

    // Monitor
    bit   inflight = 0;
    int   gcyc, vcnt;
    exp_t cur;
    always @(negedge CLK) begin
        if (!RSTn) begin
            inflight = 0;
        end else begin
            if (done == '0) chk("pass_idle", pass, 0);
            if (inflight && dp_data_valid) vcnt++;
            if (!inflight) chk("valid_idle", dp_data_valid, 0);
            if (gnt != '0) begin
                chk("gnt_busy", busy, 0);
                if (sbq.size() == 0) begin
                    chk("gnt_unexpected", gnt, 0);
                end else begin
                    cur = sbq[0];
                    chk("gnt_idx", gnt, 64'(1) << cur.idx);
                    inflight = 1;
                    gcyc = cyc;
                    vcnt = 0;
                end
            end
            if (done != '0) begin
                if (!inflight || sbq.size() == 0) begin
                    chk("done_unexpected", done, 0);
                end else begin
                    cur = sbq.pop_front();
                    chk("done_idx", done, 64'(1) << cur.idx);
                    chk("pass", pass, cur.pass);
                    chk("latency", cyc - gcyc, (cur.n == 0) ? 1 : 4*cur.n + DL + 2);
                    chk("valid_cycles", vcnt, (cur.n == 0) ? 0 : 4*cur.n + 1);
                end
                inflight = 0;
            end
        end
    end

    initial begin
        int cnt;
        req = '1; req_word = '0; req_n = '0;
        for (int i = 0; i < NR; i++) begin m_pass[i] = 0; m_fail[i] = 0; end

        repeat (3) begin
            @(negedge CLK);
            chk("rst_gnt", gnt, 0);
            chk("rst_done", done, 0);
            chk("rst_pass", pass, 0);
            chk("rst_busy", busy, 0);
            chk("rst_valid", dp_data_valid, 0);
        end
        @(posedge CLK); #1;
        req = '0; RSTn = 1'b1;

        // Held requests 1011: expect grants 0,1,3,0 back to back.
        set_slot(0, PAT, 8'd1); set_slot(1, 32'h12345678, 8'd1);
        set_slot(2, PAT, 8'd1); set_slot(3, PAT, 8'd2);
        wait_idle();
        req = 4'b1011;
        repeat (4) push_grant(4'b1011);
        cnt = 0;
        for (int t = 0; t < 500 && cnt < 4; t++) begin
            @(posedge CLK); #1;
            if (done != '0) cnt++;
            if (cnt == 4) req = '0;
        end
        chk("rr_done_count", cnt, 4);

        set_slot(0, PAT, 8'd3);          do_txn(4'b0001);
        set_slot(1, 32'hAABBCCDD, 8'd1); do_txn(4'b0010);
        set_slot(2, PAT, 8'd0);          do_txn(4'b0100);

        // Reset in the middle of RUN: aborted, no done, everything clears.
        set_slot(3, PAT, 8'd5);
        do_txn(4'b1000);
        repeat (5) @(posedge CLK);
        #1;
        RSTn = 1'b0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_valid", dp_data_valid, 0);
        chk("arst_done", done, 0);
        chk("arst_dp_in", dp_in, 0);
        chk("arst_dp_n", dp_n, 0);
        sbq.delete();
        mptr = 0;
        for (int i = 0; i < NR; i++) begin m_pass[i] = 0; m_fail[i] = 0; end
        repeat (2) @(posedge CLK);
        #1;
        RSTn = 1'b1;

        // Requester 0: three passes and two fails.
        for (int k = 0; k < 5; k++) begin
            set_slot(0, (k < 3) ? PAT : 32'h0BAD0BAD, 8'(k + 1));
            do_txn(4'b0001);
        end

        // Counter-width boundaries: 4n beyond 8 bits.
        set_slot(1, PAT, 8'd64);  do_txn(4'b0010);
        set_slot(2, PAT, 8'd255); do_txn(4'b0100);

        for (int k = 0; k < 40; k++) begin
            for (int i = 0; i < NR; i++)
                set_slot(i, ($urandom_range(0, 1) == 1) ? PAT : $urandom(), 8'($urandom_range(0, 6)));
            do_txn(4'($urandom_range(1, 15)));
        end

        cnt = 0;
        while ((sbq.size() != 0 || busy) && cnt < 3000) begin
            @(posedge CLK); #1;
            cnt++;
        end
        chk("drain_timeout", (cnt >= 3000) ? 1 : 0, 0);
        chk("queue_empty", sbq.size(), 0);
        @(negedge CLK);

`ifdef PRBS_PD_SCHED_STATS_EN
        for (int i = 0; i < NR; i++) begin
            chk("pass_cnt", pass_cnt[i*16 +: 16], m_pass[i]);
            chk("fail_cnt", fail_cnt[i*16 +: 16], m_fail[i]);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
